// File: rtl/lookup_request_arbiter.sv
// lookup_request_arbiter
//
// Round-robin arbiter that shares the single lookup port of the match CAM
// among several preprocess requesters. Each granted lookup pushes the
// requester's tag into an order-preserving FIFO. When the CAM returns a
// result, the FIFO head names the requester that receives it.
//
// Ports
//   clk             sole clock
//   resetn          asynchronous active-low reset
//   req_valid       per-requester lookup request
//   req_key         flat keys, requester i at [i*KEY_WIDTH +: KEY_WIDTH]
//   req_ready       one-hot grant (combinational, forced low in reset)
//   cam_cmd_valid   registered lookup command strobe
//   cam_cmd_key     registered lookup key
//   cam_busy        CAM cannot accept a command this cycle
//   cam_match_valid CAM result strobe; results arrive in issue order
//   cam_match       hit flag
//   cam_match_addr  matching entry
//   rsp_valid       one-hot registered response strobe
//   rsp_hit         registered hit flag
//   rsp_addr        registered match address
//   err_unexpected  sticky: CAM result arrived with no lookup in flight
module lookup_request_arbiter #(
    parameter int unsigned NUM_REQ         = 3,
    parameter int unsigned KEY_WIDTH       = 32,
    parameter int unsigned ADDR_WIDTH      = 5,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*KEY_WIDTH-1:0] req_key,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         cam_cmd_valid,
    output logic [KEY_WIDTH-1:0]         cam_cmd_key,
    input  logic                         cam_busy,
    input  logic                         cam_match_valid,
    input  logic                         cam_match,
    input  logic [ADDR_WIDTH-1:0]        cam_match_addr,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic                         rsp_hit,
    output logic [ADDR_WIDTH-1:0]        rsp_addr,
    output logic                         err_unexpected
);

    localparam int unsigned TW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    logic [TW-1:0]         rr_ptr_q;
    logic [OW-1:0]         outstanding_q;
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [TW-1:0]         tag_mem_q [MAX_OUTSTANDING];

    logic                  found;
    logic [TW-1:0]         winner;
    int                    idx;
    logic                  grant;
    logic                  pop;
    logic                  unexpected;
    logic [TW-1:0]         head_tag;
    logic [KEY_WIDTH-1:0]  winner_key;

    // First valid requester scanning upward from rr_ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            idx = (int'(rr_ptr_q) + k) % int'(NUM_REQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = TW'(idx);
            end
        end
    end

    // Uses the registered count only: a pop this cycle does not free a slot.
    assign grant      = resetn && found && !cam_busy &&
                        (outstanding_q < OW'(MAX_OUTSTANDING));
    assign pop        = cam_match_valid && (outstanding_q != '0);
    assign unexpected = cam_match_valid && (outstanding_q == '0);
    assign head_tag   = tag_mem_q[rd_ptr_q];
    assign winner_key = req_key[int'(winner)*int'(KEY_WIDTH) +: KEY_WIDTH];

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready = NUM_REQ'(1) << winner;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr_q       <= '0;
            outstanding_q  <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                tag_mem_q[i] <= '0;
            end
            cam_cmd_valid  <= 1'b0;
            cam_cmd_key    <= '0;
            rsp_valid      <= '0;
            rsp_hit        <= 1'b0;
            rsp_addr       <= '0;
            err_unexpected <= 1'b0;
        end else begin
            cam_cmd_valid <= grant;
            if (grant) begin
                cam_cmd_key         <= winner_key;
                tag_mem_q[wr_ptr_q] <= winner;
                wr_ptr_q            <= wr_ptr_q + 1'b1;
                rr_ptr_q            <= (winner == TW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            end

            rsp_valid <= '0;
            if (pop) begin
                rsp_valid <= NUM_REQ'(1) << head_tag;
                rsp_hit   <= cam_match;
                rsp_addr  <= cam_match_addr;
                rd_ptr_q  <= rd_ptr_q + 1'b1;
            end

            if (grant && !pop) begin
                outstanding_q <= outstanding_q + 1'b1;
            end else if (pop && !grant) begin
                outstanding_q <= outstanding_q - 1'b1;
            end

            if (unexpected) begin
                err_unexpected <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lookup_request_arbiter.sv
// Directed self-checking bench for lookup_request_arbiter (3 requesters,
// 4-deep tag FIFO). Inputs change 1 time unit after a rising edge and
// outputs are checked 1 time unit later, well away from the next edge.
module tb_lookup_request_arbiter;

    localparam int NR = 3;
    localparam int KW = 32;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            resetn;
    logic [NR-1:0]   req_valid;
    logic [NR*KW-1:0] req_key;
    logic [NR-1:0]   req_ready;
    logic            cam_cmd_valid;
    logic [KW-1:0]   cam_cmd_key;
    logic            cam_busy;
    logic            cam_match_valid;
    logic            cam_match;
    logic [AW-1:0]   cam_match_addr;
    logic [NR-1:0]   rsp_valid;
    logic            rsp_hit;
    logic [AW-1:0]   rsp_addr;
    logic            err_unexpected;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lookup_request_arbiter #(
        .NUM_REQ        (NR),
        .KEY_WIDTH      (KW),
        .ADDR_WIDTH     (AW),
        .MAX_OUTSTANDING(4)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .req_valid      (req_valid),
        .req_key        (req_key),
        .req_ready      (req_ready),
        .cam_cmd_valid  (cam_cmd_valid),
        .cam_cmd_key    (cam_cmd_key),
        .cam_busy       (cam_busy),
        .cam_match_valid(cam_match_valid),
        .cam_match      (cam_match),
        .cam_match_addr (cam_match_addr),
        .rsp_valid      (rsp_valid),
        .rsp_hit        (rsp_hit),
        .rsp_addr       (rsp_addr),
        .err_unexpected (err_unexpected)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid       = '0;
        cam_busy        = 1'b0;
        cam_match_valid = 1'b0;
        cam_match       = 1'b0;
        cam_match_addr  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        next_cycle();
        resetn = 1'b1;
    endtask

    function automatic logic [NR-1:0] onehot(input int i);
        return NR'(1) << i;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req_key = {32'h0000_0102, 32'h0000_0101, 32'h0A00_0001};
        clear_inputs();
        resetn = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_cmd_valid", cam_cmd_valid, 0);
        chk("rst_cmd_key", cam_cmd_key, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_hit", rsp_hit, 0);
        chk("rst_rsp_addr", rsp_addr, 0);
        chk("rst_err", err_unexpected, 0);
        next_cycle();
        next_cycle();
        resetn = 1'b1;

        // Single request; CAM answers two cycles after the command.
        req_valid = 3'b001;
        #1;
        chk("single_grant", req_ready, 3'b001);
        next_cycle();
        req_valid = '0;
        #1;
        chk("single_cmd_valid", cam_cmd_valid, 1);
        chk("single_cmd_key", cam_cmd_key, 32'h0A00_0001);
        next_cycle();
        #1;
        chk("single_cmd_pulse", cam_cmd_valid, 0);
        next_cycle();
        cam_match_valid = 1'b1;
        cam_match       = 1'b1;
        cam_match_addr  = 5'd5;
        #1;
        chk("single_no_early_rsp", rsp_valid, 0);
        next_cycle();
        clear_inputs();
        #1;
        chk("single_rsp_valid", rsp_valid, 3'b001);
        chk("single_rsp_hit", rsp_hit, 1);
        chk("single_rsp_addr", rsp_addr, 5);
        next_cycle();
        #1;
        chk("single_rsp_pulse", rsp_valid, 0);

        // Round-robin with all requesters held and immediate CAM results.
        do_reset();
        for (int n = 0; n < 8; n++) begin
            req_valid       = (n < 6) ? 3'b111 : 3'b000;
            cam_match_valid = (n >= 1 && n <= 6);
            cam_match       = ((n - 1) % 2) == 1;
            cam_match_addr  = AW'(n - 1);
            #1;
            chk($sformatf("rr_ready_%0d", n), req_ready, (n < 6) ? onehot(n % 3) : 3'b000);
            chk($sformatf("rr_cmd_valid_%0d", n), cam_cmd_valid, (n >= 1 && n <= 6));
            if (n >= 1 && n <= 6) begin
                chk($sformatf("rr_cmd_key_%0d", n), cam_cmd_key, 32'h0A00_0001 +
                    (((n - 1) % 3) == 0 ? 0 : 32'h0000_0101 - 32'h0A00_0001 + ((n - 1) % 3) - 1));
            end
            chk($sformatf("rr_rsp_valid_%0d", n), rsp_valid,
                (n >= 2) ? onehot((n - 2) % 3) : 3'b000);
            if (n >= 2) begin
                chk($sformatf("rr_rsp_addr_%0d", n), rsp_addr, n - 2);
                chk($sformatf("rr_rsp_hit_%0d", n), rsp_hit, ((n - 2) % 2) == 1);
            end
            next_cycle();
        end
        clear_inputs();

        // Full: four grants with no results, then one pop frees one slot.
        do_reset();
        req_valid = 3'b111;
        for (int n = 0; n < 7; n++) begin
            #1;
            chk($sformatf("full_ready_%0d", n), req_ready, (n < 4) ? onehot(n % 3) : 3'b000);
            next_cycle();
        end
        cam_match_valid = 1'b1;
        cam_match_addr  = 5'd9;
        #1;
        chk("full_no_bypass", req_ready, 3'b000);
        next_cycle();
        cam_match_valid = 1'b0;
        #1;
        chk("full_regrant", req_ready, 3'b010);
        chk("full_rsp_head", rsp_valid, 3'b001);
        next_cycle();
        #1;
        chk("full_again", req_ready, 3'b000);

        // cam_busy blocks grants for five cycles.
        do_reset();
        req_valid = 3'b100;
        cam_busy  = 1'b1;
        for (int n = 0; n < 5; n++) begin
            #1;
            chk($sformatf("busy_ready_%0d", n), req_ready, 3'b000);
            chk($sformatf("busy_cmd_%0d", n), cam_cmd_valid, 0);
            next_cycle();
        end
        cam_busy = 1'b0;
        #1;
        chk("busy_resume", req_ready, 3'b100);
        next_cycle();
        req_valid = '0;
        #1;
        chk("busy_cmd_valid", cam_cmd_valid, 1);
        chk("busy_cmd_key", cam_cmd_key, 32'h0000_0102);

        // Result with nothing in flight.
        do_reset();
        cam_match_valid = 1'b1;
        cam_match       = 1'b1;
        next_cycle();
        clear_inputs();
        #1;
        chk("unexp_err", err_unexpected, 1);
        chk("unexp_no_rsp", rsp_valid, 0);
        chk("unexp_outstanding", dut.outstanding_q, 0);
        next_cycle();
        next_cycle();
        #1;
        chk("unexp_err_sticky", err_unexpected, 1);
        chk("unexp_no_rsp_late", rsp_valid, 0);

        // Asynchronous reset with two lookups in flight.
        do_reset();
        req_valid = 3'b001;
        #1;
        chk("arst_grant0", req_ready, 3'b001);
        next_cycle();
        req_valid = 3'b010;
        #1;
        chk("arst_grant1", req_ready, 3'b010);
        next_cycle();
        req_valid = 3'b011;
        #1;
        chk("arst_cmd_before", cam_cmd_valid, 1);
        resetn = 1'b0;
        #1;
        chk("arst_ready", req_ready, 3'b000);
        chk("arst_cmd_valid", cam_cmd_valid, 0);
        chk("arst_cmd_key", cam_cmd_key, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_err", err_unexpected, 0);
        next_cycle();
        resetn    = 1'b1;
        req_valid = 3'b110;
        #1;
        chk("arst_post_grant", req_ready, 3'b010);
        next_cycle();
        req_valid = '0;
        #1;
        chk("arst_post_cmd", cam_cmd_valid, 1);
        chk("arst_post_key", cam_cmd_key, 32'h0000_0101);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
